// File: rtl/asi_regfile_pkg.sv
`default_nettype none
//==== asi_regfile_pkg : word map, ID default and read-FSM state type ======
//==== rev 1.0 ==============================================================
package asi_regfile_pkg;

  localparam int REG_ID     = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_CTRL   = 2;
  localparam int REG_IRQEN  = 3;
  localparam int REG_CFG0   = 4;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4153_0001;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/asi_regfile_rdctl.sv
`default_nettype none
//==== asi_regfile_rdctl : read FSM with fixed response latency =============
//==== rev 1.0 ==============================================================
module asi_regfile_rdctl
  import asi_regfile_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic r_rvalid,
  output logic capture,
  output logic r_rready
);

  localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((RD_LAT > 2) ? (RD_LAT - 2) : 0);

  rd_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= R_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    r_rready  = 1'b0;
    case (state)
      R_IDLE: begin
        if (r_rvalid) begin
          capture = 1'b1;
          if (RD_LAT == 1) begin
            state_nxt = R_RESP;
          end else begin
            state_nxt = R_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      R_WAIT: begin
        if (cnt == '0) state_nxt = R_RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      R_RESP: begin
        // request is ignored here so a held r_rvalid cannot re-trigger
        r_rready  = 1'b1;
        state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/asi_regfile.sv
`default_nettype none
//==== asi_regfile : config/status register bank with W1C status and irq ====
//==== rev 1.0 ==============================================================
module asi_regfile
  import asi_regfile_pkg::*;
#(
  parameter int          AXI_SW     = 3,
  parameter int          REG_AW     = 20,
  parameter int          REG_DW     = 32,
  parameter int          REG_WSTRBW = REG_DW / 8,
  parameter int          L          = $clog2(REG_DW / 8),
  parameter int          NUM_REGS   = 16,
  parameter int          RD_LAT     = 1,
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXI_SW-1:0]          r_wsize,
  input  logic [REG_AW-1:L]          r_waddr,
  input  logic [REG_DW-1:0]          r_wdata,
  input  logic [REG_WSTRBW-1:0]      r_wstrb,
  input  logic                       r_wlast,
  input  logic                       r_wvalid,
  output logic                       r_wready,
  input  logic [AXI_SW-1:0]          r_rsize,
  input  logic [REG_AW-1:L]          r_raddr,
  input  logic                       r_rvalid,
  output logic [REG_DW-1:0]          r_rdata,
  output logic                       r_rready,
  input  logic [31:0]                hw_set,
  output logic [31:0]                cfg_ctrl,
  output logic [(NUM_REGS-4)*32-1:0] cfg_regs,
  output logic                       irq,
  output logic                       addr_err
);

  localparam int AW   = REG_AW - L;
  localparam int NCFG = NUM_REGS - 4;

  logic [REG_DW-1:0] status, ctrl, irqen;
  logic [REG_DW-1:0] cfg [NCFG];
  logic [REG_DW-1:0] wmask, w1c, rd_val;
  logic              wr_en, w_oor, r_oor, capture;

  logic unused_ok;
  assign unused_ok = ^{r_wsize, r_rsize, r_wlast};

  always_comb begin
    wmask = '0;
    for (int b = 0; b < REG_WSTRBW; b++) wmask[b*8 +: 8] = {8{r_wstrb[b]}};
  end

  function automatic logic [REG_DW-1:0] merge(input logic [REG_DW-1:0] old,
                                              input logic [REG_DW-1:0] data,
                                              input logic [REG_DW-1:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  assign wr_en = r_wvalid & r_wready;
  assign w_oor = r_waddr >= AW'(NUM_REGS);
  assign r_oor = r_raddr >= AW'(NUM_REGS);
  assign w1c   = (wr_en && r_waddr == AW'(REG_STATUS)) ? (r_wdata & wmask) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wready <= 1'b0;
      status   <= '0;
      ctrl     <= '0;
      irqen    <= '0;
      irq      <= 1'b0;
      addr_err <= 1'b0;
      for (int i = 0; i < NCFG; i++) cfg[i] <= '0;
    end else begin
      r_wready <= 1'b1;
      // hardware set is OR-ed after the clear so it wins a same-cycle collision
      status   <= (status & ~w1c) | hw_set;
      if (wr_en && r_waddr == AW'(REG_CTRL))  ctrl  <= merge(ctrl, r_wdata, wmask);
      if (wr_en && r_waddr == AW'(REG_IRQEN)) irqen <= merge(irqen, r_wdata, wmask);
      for (int i = 0; i < NCFG; i++)
        if (wr_en && r_waddr == AW'(REG_CFG0 + i)) cfg[i] <= merge(cfg[i], r_wdata, wmask);
      irq      <= |(status & irqen);
      addr_err <= (wr_en & w_oor) | (capture & r_oor);
    end
  end

  always_comb begin
    rd_val = '0;
    if (r_raddr == AW'(REG_ID))     rd_val = ID_VALUE;
    if (r_raddr == AW'(REG_STATUS)) rd_val = status;
    if (r_raddr == AW'(REG_CTRL))   rd_val = ctrl;
    if (r_raddr == AW'(REG_IRQEN))  rd_val = irqen;
    for (int i = 0; i < NCFG; i++)
      if (r_raddr == AW'(REG_CFG0 + i)) rd_val = cfg[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rdata <= '0;
    else if (capture) r_rdata <= rd_val;
  end

  asi_regfile_rdctl #(.RD_LAT(RD_LAT)) u_rdctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_rvalid (r_rvalid),
    .capture  (capture),
    .r_rready (r_rready)
  );

  assign cfg_ctrl = ctrl;

  for (genvar i = 0; i < NCFG; i++) begin : g_cfg_out
    assign cfg_regs[i*32 +: 32] = cfg[i];
  end

endmodule
`default_nettype wire
